// File: rtl/uart_rx_pkg.sv
// uart_rx shared definitions: register select, status bits,
// receiver FSM encodings and small helpers.
package uart_rx_pkg;

  localparam logic UART_RX_REG_DATA   = 1'b0;
  localparam logic UART_RX_REG_STATUS = 1'b1;

  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_FRAME   = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [31:0] DATA_EMPTY = 32'h8000_0000;

  function automatic logic [3:0] sat_cnt(
    input logic [31:0] n
  );
    return (n > 32'd15) ? 4'hf : n[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Request side of the picorv32 native bus as seen
// by the uart_rx peripheral.
interface uart_rx_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;

  modport master (
    output enable, mem_valid, mem_instr,
    output mem_wstrb, mem_wdata, mem_addr
  );

  modport slave (
    input enable, mem_valid, mem_instr,
    input mem_wstrb, mem_wdata, mem_addr
  );
endinterface

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock FIFO, power-of-two depth. A pop in the
// same cycle as a push on a full FIFO frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with polled status
// and a receive FIFO on the picorv32 native bus.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  uart_rx_if.slave    bus,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);
  localparam int BIT_CYCLES  = CLK_HZ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CW   = $clog2(BIT_CYCLES);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_m, rx_s, rx_s_d;
  logic          fall;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          bit_end, half_end;
  logic          stop_smp, push, frame_set;

  logic            ack, req;
  logic            sel_q, wr_q, ws0_q;
  logic [1:0]      clr_q;
  logic            pop, w1c, ovf_set;
  logic            overrun, frame_err;
  logic [7:0]      head;
  logic            full, empty;
  logic [CNTW-1:0] count;
  logic [31:0]     status_w, data_w, rd_mux;
  logic            unused_bits;

  assign fall     = rx_s_d & ~rx_s;
  assign bit_end  = (cnt == CW'(BIT_CYCLES - 1));
  assign half_end = (cnt == CW'(HALF_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= serialIn;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (half_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Sampled stop bit decides push vs framing error.
  assign stop_smp  = (state == S_STOP) & bit_end;
  assign push      = stop_smp & rx_s;
  assign frame_set = stop_smp & ~rx_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (push),
    .pop   (pop),
    .wdata (shift),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign req = bus.mem_valid & bus.enable & ~ack;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ack   <= 1'b0;
      sel_q <= 1'b0;
      wr_q  <= 1'b0;
      ws0_q <= 1'b0;
      clr_q <= '0;
    end else begin
      ack <= req;
      if (req) begin
        sel_q <= bus.mem_addr[2];
        wr_q  <= |bus.mem_wstrb;
        ws0_q <= bus.mem_wstrb[0];
        clr_q <= bus.mem_wdata[3:2];
      end
    end
  end

  assign pop = ack & ~wr_q & ~empty
             & (sel_q == UART_RX_REG_DATA);
  assign w1c = ack & wr_q & ws0_q
             & (sel_q == UART_RX_REG_STATUS);
  assign ovf_set = push & full & ~pop;

  // Set beats clear when both land in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_set)             overrun <= 1'b1;
      else if (w1c & clr_q[0]) overrun <= 1'b0;
      if (frame_set)           frame_err <= 1'b1;
      else if (w1c & clr_q[1]) frame_err <= 1'b0;
    end
  end

  always_comb begin
    status_w = '0;
    status_w[ST_NEMPTY]  = ~empty;
    status_w[ST_FULL]    = full;
    status_w[ST_OVERRUN] = overrun;
    status_w[ST_FRAME]   = frame_err;
    status_w[ST_CNT_LSB +: 4] = sat_cnt(32'(count));
  end

  assign data_w = empty ? DATA_EMPTY : {24'h0, head};
  assign rd_mux = (sel_q == UART_RX_REG_STATUS)
                ? status_w : data_w;

  assign mem_ready = ack ? 1'b1 : 1'bz;
  assign mem_rdata = ack ? rd_mux : 32'bz;

  assign unused_bits = ^{bus.mem_instr,
                         bus.mem_addr[31:3],
                         bus.mem_addr[1:0],
                         bus.mem_wdata[31:4],
                         bus.mem_wdata[1:0]};
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a queue-based
// model of the receiver's FIFO, flags and register map.
module tb_uart_rx;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        serial_in = 1'b1;
  wire         mem_ready;
  wire  [31:0] mem_rdata;

  uart_rx_if bus_if ();

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_if.slave),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .serialIn  (serial_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  byte unsigned q[$];
  bit ov_m = 1'b0;
  bit fe_m = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    logic [31:0] s;
    n = q.size();
    s = '0;
    s[0] = (n != 0);
    s[1] = (n == DEPTH);
    s[2] = ov_m;
    s[3] = fe_m;
    s[11:8] = (n > 15) ? 4'd15 : 4'(n);
    return s;
  endfunction

  task automatic send(input logic [7:0] b,
                      input bit stop);
    serial_in = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      cyc(BIT);
    end
    serial_in = stop;
    cyc(BIT);
    serial_in = 1'b1;
    cyc(4);
    if (!stop) fe_m = 1'b1;
    else if (q.size() < DEPTH) q.push_back(b);
    else ov_m = 1'b1;
  endtask

  task automatic txn(input bit a2,
                     input logic [3:0] ws,
                     input logic [31:0] wd,
                     output logic [31:0] rd);
    int w;
    bit seen;
    w = 0;
    seen = 1'b0;
    rd = 'x;
    bus_if.enable    = 1'b1;
    bus_if.mem_valid = 1'b1;
    bus_if.mem_instr = 1'($urandom);
    bus_if.mem_addr  = ($urandom & ~32'h4)
                     | {29'h0, a2, 2'b00};
    bus_if.mem_wstrb = ws;
    bus_if.mem_wdata = wd;
    while (!seen && w < 8) begin
      cyc(1);
      w++;
      if (mem_ready === 1'b1) begin
        seen = 1'b1;
        rd = mem_rdata;
      end
    end
    bus_if.mem_valid = 1'b0;
    bus_if.enable    = 1'b0;
    bus_if.mem_wstrb = 4'h0;
    check("ack_latency", 32'(w), 32'd1);
    cyc(1);
    check("ready_one_cycle",
          {31'h0, mem_ready === 1'b1}, 32'd0);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] rd, e;
    txn(1'b0, 4'h0, $urandom, rd);
    if (q.size() == 0) e = 32'h8000_0000;
    else e = {24'h0, q.pop_front()};
    check(tag, rd, e);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] rd;
    txn(1'b1, 4'h0, $urandom, rd);
    check(tag, rd, exp_status());
  endtask

  task automatic write_status(input logic [31:0] wd);
    logic [31:0] rd;
    txn(1'b1, 4'h1 | 4'($urandom), wd, rd);
    if (wd[2]) ov_m = 1'b0;
    if (wd[3]) fe_m = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    bus_if.enable    = 1'b0;
    bus_if.mem_valid = 1'b0;
    bus_if.mem_instr = 1'b0;
    bus_if.mem_wstrb = 4'h0;
    bus_if.mem_wdata = '0;
    bus_if.mem_addr  = '0;
    cyc(3);
    check("reset_ready_idle",
          {31'h0, mem_ready === 1'b1}, 32'd0);
    resetn = 1'b1;
    cyc(2);
    read_status("reset_status");

    read_data("empty_read");
    read_status("empty_read_no_change");

    send(8'hA5, 1'b1);
    read_status("a5_status");
    read_data("a5_data");
    read_status("a5_drained");

    for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
    read_status("full_overrun");
    for (int i = 0; i < 8; i++) read_data("drain");
    read_status("drained_overrun");
    write_status(32'h4);
    read_status("overrun_cleared");

    send(8'h3C, 1'b0);
    read_status("frame_err");
    send(8'h5A, 1'b1);
    read_status("after_frame_err");
    read_data("5a_data");
    write_status(32'h8);
    read_status("frame_err_cleared");

    serial_in = 1'b0;
    cyc(5);
    serial_in = 1'b1;
    cyc(3 * BIT);
    read_status("glitch");

    send(8'hC3, 1'b1);
    txn(1'b0, 4'hF, 32'hFFFF_FFFF, rd);
    read_status("data_write_ignored");

    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1);
    send(8'h11, 1'b0);
    read_status("pre_reset");
    serial_in = 1'b0;
    cyc(BIT);
    serial_in = 1'b1;
    cyc(3 * BIT + 5);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    q.delete();
    ov_m = 1'b0;
    fe_m = 1'b0;
    cyc(8 * BIT);
    read_status("mid_frame_reset");
    send(8'h7E, 1'b1);
    read_data("7e_data");

    for (int it = 0; it < 24; it++) begin
      b = 8'($urandom);
      send(b, $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) read_status("rnd_status");
      for (int r = $urandom_range(0, 1); r > 0; r--)
        read_data("rnd_data");
      if ($urandom_range(0, 5) == 0)
        write_status({28'h0, 2'($urandom), 2'b00});
    end
    read_status("rnd_final_status");
    while (q.size() != 0) read_data("rnd_drain");
    read_data("rnd_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
